mult_accumulator: RTL
=====================

MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 The block SHALL have one clock, clk1; reset is synchronous and active-low on rst_n.
REQ-002 The block SHALL have parameter N, default 8, meaning the number of products per sum (legal range 1..16).
REQ-003 Port clk1, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 Port C, input, 8 bits: unsigned product from the upstream 4x4 multiplier.
REQ-006 Port c_valid, input, 1 bit: C holds a valid product.
REQ-007 Port c_last, input, 1 bit: qualifies C as the final product of the current group (early terminate).
REQ-008 Port c_ready, output, 1 bit: the block accepts C this cycle.
REQ-009 Port S, output, 10 bits: unsigned accumulated sum.
REQ-010 Port s_valid, output, 1 bit: S is valid.
REQ-011 Port s_ready, input, 1 bit: downstream takes S this cycle.
REQ-012 Port s_ovf, output, 1 bit: the exact sum of the presented group exceeded 1023.

Function
REQ-013 An input beat SHALL transfer only when c_valid and c_ready are both 1 at a rising edge of clk1; an output handoff SHALL occur only when s_valid and s_ready are both 1.
REQ-014 The FSM SHALL have three states: IDLE (no group open), ACC (group open, result not ready) and HOLD (result presented).
REQ-015 c_ready SHALL equal 1 in IDLE and ACC, and SHALL equal s_ready in HOLD; this is combinational from state and s_ready.
REQ-016 The internal accumulator SHALL be 12 bits wide, so a sum of at most 16 x 225 = 3600 never wraps internally; a 5-bit beat counter SHALL be kept.
REQ-017 The first beat of a group SHALL load acc=C and cnt=1. Each following beat SHALL apply acc=acc+C and cnt=cnt+1.
REQ-018 A group SHALL close on the beat where cnt reaches N or c_last=1, whichever is first.
REQ-019 On the closing beat, S and s_ovf SHALL be registered from the full sum, and the FSM SHALL enter HOLD with s_valid=1 on the next cycle. Latency is one cycle from the last beat to s_valid.
REQ-020 IDLE SHALL go to ACC on a non-closing first beat, and SHALL go to HOLD on a closing first beat (N=1 or c_last=1).
REQ-021 ACC SHALL stay in ACC on non-closing beats and SHALL go to HOLD on the closing beat. ACC with no beat SHALL hold all state.
REQ-022 In HOLD, S, s_ovf and s_valid SHALL remain stable until the handoff.
REQ-023 On a HOLD handoff with no input beat, the FSM SHALL go to IDLE with s_valid=0 the next cycle.
REQ-024 On a HOLD handoff with a simultaneous input beat, the result SHALL be handed off and the beat SHALL start a new group per REQ-017 and REQ-020, with no bubble.
REQ-025 c_last SHALL be ignored when c_valid=0; C SHALL be ignored when no input beat occurs.

Reset
REQ-026 While rst_n=0 at a rising edge of clk1: state=IDLE, acc=0, cnt=0, S=0, s_valid=0, s_ovf=0; c_ready therefore reads 1.
REQ-027 Reset mid-group or in HOLD SHALL discard the partial or presented result without any handoff.

Configuration
REQ-028 With macro MULT_ACC_SAT_EN defined, S SHALL equal min(sum, 1023); without it, S SHALL equal sum mod 1024. In both builds, s_ovf SHALL be 1 exactly when sum > 1023.

Verification
REQ-029 Reset scenario: rst_n=0 for 2 cycles with c_valid=1 and C=0xFF -> S=0, s_valid=0, s_ovf=0, c_ready=1, and no group is open after release.
REQ-030 Full-group scenario: N=8, eight back-to-back beats of C=15, s_ready=1 -> S=120, s_ovf=0, s_valid high exactly one cycle after beat 8.
REQ-031 Overflow scenario: N=8, eight beats of C=225 -> with MULT_ACC_SAT_EN, S=1023 and s_ovf=1; without it, S=776 and s_ovf=1.
REQ-032 Early-terminate scenario: beats C=10, 20, 30 with c_last on the third beat -> S=60, the next beat opens a fresh group.
REQ-033 Backpressure scenario: result S=120 held with s_ready=0 for 5 cycles -> S stable and c_ready=0. Then s_ready=1 with c_valid=1 and C=7 -> handoff occurs, the new group starts with acc=7, and N=1 yields S=7 the next cycle.
REQ-034 Mid-group reset scenario: 3 beats of C=50, then rst_n=0 for 1 cycle, then 8 beats of C=1 -> S=8, not 158.

Source files
------------

// File: rtl/mult_accumulator.sv
// Accumulates groups of up to N unsigned 8-bit products into a 10-bit sum with overflow flag.
// Build option: define MULT_ACC_SAT_EN to saturate S at 1023 instead of wrapping.
//
// state | meaning
// IDLE  | no group open
// ACC   | group open, result not ready
// HOLD  | result presented on S, waiting for s_ready
module mult_accumulator #(
  parameter int N = 8
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic [7:0] C,
  input  logic       c_valid,
  input  logic       c_last,
  output logic       c_ready,
  output logic [9:0] S,
  output logic       s_valid,
  input  logic       s_ready,
  output logic       s_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [4:0] N_L = 5'(N);

  state_t      state_q, state_d;
  logic [11:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [9:0]  s_q, s_d;
  logic        ovf_q, ovf_d;

  logic        beat;
  logic        closing;
  logic [11:0] sum;
  logic [4:0]  cnt_n;
  logic [9:0]  s_res;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    c_ready = (state_q == HOLD) ? s_ready : 1'b1;
    beat    = c_valid & c_ready;

    // Only ACC extends a group; a beat in IDLE or HOLD (during handoff) starts a new one.
    if (state_q == ACC) begin
      sum   = acc_q + {4'b0000, C};
      cnt_n = cnt_q + 5'd1;
    end else begin
      sum   = {4'b0000, C};
      cnt_n = 5'd1;
    end
    closing = c_last | (cnt_n == N_L);

`ifdef MULT_ACC_SAT_EN
    s_res = (sum > 12'd1023) ? 10'd1023 : sum[9:0];
`else
    s_res = sum[9:0];
`endif

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    ovf_d   = ovf_q;

    if (beat) begin
      acc_d = sum;
      cnt_d = cnt_n;
      if (closing) begin
        state_d = HOLD;
        s_d     = s_res;
        ovf_d   = (sum > 12'd1023);
      end else begin
        state_d = ACC;
      end
    end else if ((state_q == HOLD) && s_ready) begin
      state_d = IDLE;
    end
  end

  assign S       = s_q;
  assign s_ovf   = ovf_q;
  assign s_valid = (state_q == HOLD);

endmodule
